// File: rtl/tile_fetch_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tile_fetch_sched_if                                           |
// | Brief    : Raster, CPU bus, video RAM and tile output signals of the     |
// |            tile fetch scheduler, bundled with master/slave views.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface tile_fetch_sched_if;
  // Raster timing
  logic [8:0]  row;
  logic [9:0]  col;
  logic        de;
  logic        line_start;
  // CPU bus
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  // Video RAM port
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  // Tile outputs to tile_block
  logic [7:0]  tile_ROM_addr;
  logic [5:0]  palette_ROM_addr;

  // Environment side: timing generator, CPU and RAM drive the scheduler
  modport master (
    output row, col, de, line_start,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    input  tile_ROM_addr, palette_ROM_addr
  );

  // Scheduler side
  modport slave (
    input  row, col, de, line_start,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    output tile_ROM_addr, palette_ROM_addr
  );
endinterface
`default_nettype wire

// File: rtl/tile_fetch_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tile_fetch_sched                                              |
// | Brief    : Time-slices the shared video RAM port between tile code /     |
// |            palette prefetch and CPU accesses, double-buffering the       |
// |            fetched bytes so tile outputs stay stable for a whole tile.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tile_fetch_sched #(
  parameter logic [15:0] TILE_BASE = 16'h4000,
  parameter logic [15:0] PAL_BASE  = 16'h4400
) (
  input  logic               clk,
  input  logic               rst,
  tile_fetch_sched_if.slave  bus
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PRE_CODE = 2'd1;
  localparam logic [1:0] S_PRE_PAL  = 2'd2;
  localparam logic [1:0] S_PRE_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [7:0]  nxt_code_q;
  logic [5:0]  nxt_pal_q;
  logic [7:0]  tile_q;
  logic [5:0]  pal_q;
  logic        rd_pend_q;

  logic        w_row_vis;
  logic [2:0]  w_phase;
  logic [7:0]  w_tnext;
  logic        w_tnext_ok;
  logic        w_active;
  logic [15:0] w_off_act;
  logic [15:0] w_off_pre;
  logic        w_vid_code;
  logic        w_vid_pal;
  logic [15:0] w_vid_addr;
  logic        w_grant;
  logic        w_wr_grant;
  logic        w_rd_grant;
  logic        w_unused;

  assign w_row_vis  = (bus.row < 9'd128);
  assign w_phase    = bus.col[2:0];
  assign w_tnext    = {1'b0, bus.col[9:3]} + 8'd1;
  assign w_tnext_ok = (w_tnext < 8'd16);

  // Active slots are only honoured once any line prefetch has finished.
  assign w_active   = !rst && bus.de && (state_q == S_IDLE) && w_row_vis;

  // RAM offset {tile row, tile index}; the prefetch always targets tile 0.
  assign w_off_act  = {8'h00, bus.row[6:3], w_tnext[3:0]};
  assign w_off_pre  = {8'h00, bus.row[6:3], 4'h0};

  assign w_vid_code = !rst && ((state_q == S_PRE_CODE) ||
                               (w_active && (w_phase == 3'd0) && w_tnext_ok));
  assign w_vid_pal  = !rst && ((state_q == S_PRE_PAL) ||
                               (w_active && (w_phase == 3'd1) && w_tnext_ok));

  // Video slots always win; the CPU gets every other cycle unless a read
  // is still waiting for its data to come back.
  assign w_grant    = !rst && bus.cpu_req && !rd_pend_q && !w_vid_code && !w_vid_pal;
  assign w_wr_grant = w_grant && bus.cpu_we;
  assign w_rd_grant = w_grant && !bus.cpu_we;

  assign w_unused   = ^{bus.row[2:0], bus.mem_rdata[7:6]};

  // Video address for whichever fetch slot is active this cycle
  always_comb begin
    w_vid_addr = 16'h0000;
    if (state_q == S_PRE_CODE) begin
      w_vid_addr = TILE_BASE + w_off_pre;
    end else if (state_q == S_PRE_PAL) begin
      w_vid_addr = PAL_BASE + w_off_pre;
    end else if (w_phase == 3'd0) begin
      w_vid_addr = TILE_BASE + w_off_act;
    end else begin
      w_vid_addr = PAL_BASE + w_off_act;
    end
  end

  // Memory port mux: video fetch, CPU grant, or parked at address 0
  always_comb begin
    bus.mem_addr  = 16'h0000;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = 8'h00;
    if (w_vid_code || w_vid_pal) begin
      bus.mem_addr = w_vid_addr;
    end else if (w_grant) begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_we    = bus.cpu_we;
      bus.mem_wdata = bus.cpu_we ? bus.cpu_wdata : 8'h00;
    end
  end

  // Write acks in the grant cycle; read acks one cycle later with RAM data.
  assign bus.cpu_ack   = w_wr_grant || (rd_pend_q && !rst);
  assign bus.cpu_rdata = (rd_pend_q && !rst) ? bus.mem_rdata : 8'h00;

  assign bus.tile_ROM_addr    = tile_q;
  assign bus.palette_ROM_addr = pal_q;

  // Prefetch sequencer next state: one cycle per state after line_start
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (bus.line_start && w_row_vis) state_d = S_PRE_CODE;
      S_PRE_CODE: state_d = S_PRE_PAL;
      S_PRE_PAL:  state_d = S_PRE_DONE;
      S_PRE_DONE: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Prefetch sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outstanding CPU read flag; a reset drops the pending read without an ack
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q <= 1'b0;
    end else begin
      rd_pend_q <= w_rd_grant;
    end
  end

  // Next-tile buffer capture and once-per-tile transfer to the outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      nxt_code_q <= 8'h00;
      nxt_pal_q  <= 6'h00;
      tile_q     <= 8'h00;
      pal_q      <= 6'h00;
    end else if (state_q == S_PRE_PAL) begin
      nxt_code_q <= bus.mem_rdata;
    end else if (state_q == S_PRE_DONE) begin
      // Tile 0 must be visible before the first pixel, so bypass the buffer.
      nxt_pal_q <= bus.mem_rdata[5:0];
      tile_q    <= nxt_code_q;
      pal_q     <= bus.mem_rdata[5:0];
    end else if (w_active) begin
      if ((w_phase == 3'd1) && w_tnext_ok) begin
        nxt_code_q <= bus.mem_rdata;
      end
      if ((w_phase == 3'd2) && w_tnext_ok) begin
        nxt_pal_q <= bus.mem_rdata[5:0];
      end
      if (w_phase == 3'd7) begin
        // Past the last tile of the window the outputs blank to 0.
        tile_q <= w_tnext_ok ? nxt_code_q : 8'h00;
        pal_q  <= w_tnext_ok ? nxt_pal_q  : 6'h00;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tile_fetch_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_tile_fetch_sched                                           |
// | Brief    : Directed self-checking bench for tile_fetch_sched with a      |
// |            behavioural video RAM.                                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_tile_fetch_sched;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  bit [7:0] ram [65536];

  tile_fetch_sched_if bus ();

  tile_fetch_sched #(
    .TILE_BASE (16'h4000),
    .PAL_BASE  (16'h4400)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Synchronous video RAM: write on strobe, read data one cycle after address
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Next pixel: clock edge, then column advances by one
  task automatic adv();
    tick();
    bus.col = bus.col + 10'd1;
  endtask

  // CPU write while the port is otherwise idle: acked in the grant cycle
  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    #1;
    chk("wr_ack", {15'd0, bus.cpu_ack}, 16'd1);
    chk("wr_mem_we", {15'd0, bus.mem_we}, 16'd1);
    tick();
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.row        = 9'd0;
    bus.col        = 10'd0;
    bus.de         = 1'b0;
    bus.line_start = 1'b0;
    bus.cpu_req    = 1'b1;
    bus.cpu_we     = 1'b0;
    bus.cpu_addr   = 16'h1234;
    bus.cpu_wdata  = 8'h5A;

    // Reset held two cycles with a CPU request pending
    tick();
    #1;
    chk("rst_ack", {15'd0, bus.cpu_ack}, 16'd0);
    chk("rst_mem_addr", bus.mem_addr, 16'h0000);
    chk("rst_tile", {8'd0, bus.tile_ROM_addr}, 16'h0000);
    chk("rst_pal", {10'd0, bus.palette_ROM_addr}, 16'h0000);
    bus.cpu_we = 1'b1;
    tick();
    #1;
    chk("rst_ack2", {15'd0, bus.cpu_ack}, 16'd0);
    chk("rst_mem_we", {15'd0, bus.mem_we}, 16'd0);
    chk("rst_rdata", {8'd0, bus.cpu_rdata}, 16'h0000);
    rst         = 1'b0;
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    tick();
    #1;
    chk("idle_mem_addr", bus.mem_addr, 16'h0000);

    // Preload video RAM through the CPU port during blanking
    cpu_wr(16'h4000, 8'h12);
    cpu_wr(16'h4400, 8'h05);
    cpu_wr(16'h4012, 8'hAB);
    cpu_wr(16'h4412, 8'h3F);
    cpu_wr(16'h401F, 8'h9A);
    cpu_wr(16'h441F, 8'h21);
    cpu_wr(16'h5000, 8'hC3);

    // Line prefetch for row 0
    bus.row        = 9'd0;
    bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    #1;
    chk("pre_code_addr", bus.mem_addr, 16'h4000);
    chk("pre_code_we", {15'd0, bus.mem_we}, 16'd0);
    tick();
    #1;
    chk("pre_pal_addr", bus.mem_addr, 16'h4400);
    tick();
    tick();
    #1;
    chk("pre_tile", {8'd0, bus.tile_ROM_addr}, 16'h0012);
    chk("pre_pal", {10'd0, bus.palette_ROM_addr}, 16'h0005);

    // Active scan on row 8 starting at tile 1
    bus.row = 9'd8;
    tick();
    bus.de  = 1'b1;
    bus.col = 10'd8;
    #1;
    chk("act_code_addr", bus.mem_addr, 16'h4012);
    adv();
    #1;
    chk("act_pal_addr", bus.mem_addr, 16'h4412);
    while (bus.col != 10'd15) adv();
    #1;
    chk("act_hold_tile", {8'd0, bus.tile_ROM_addr}, 16'h0012);
    adv();
    #1;
    chk("act_tile16", {8'd0, bus.tile_ROM_addr}, 16'h00AB);
    chk("act_pal16", {10'd0, bus.palette_ROM_addr}, 16'h003F);
    while (bus.col != 10'd23) adv();
    #1;
    chk("act_tile23", {8'd0, bus.tile_ROM_addr}, 16'h00AB);
    adv();

    // CPU read arriving at phase 0 (col 24): granted phase 2, acked phase 3
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 16'h5000;
    #1;
    chk("cont_p0_addr", bus.mem_addr, 16'h4014);
    chk("cont_p0_ack", {15'd0, bus.cpu_ack}, 16'd0);
    adv();
    #1;
    chk("cont_p1_addr", bus.mem_addr, 16'h4414);
    adv();
    #1;
    chk("cont_p2_addr", bus.mem_addr, 16'h5000);
    chk("cont_p2_ack", {15'd0, bus.cpu_ack}, 16'd0);
    adv();
    #1;
    chk("cont_p3_ack", {15'd0, bus.cpu_ack}, 16'd1);
    chk("cont_p3_rdata", {8'd0, bus.cpu_rdata}, 16'h00C3);
    chk("cont_p3_noregrant", bus.mem_addr, 16'h0000);
    bus.cpu_req = 1'b0;
    adv();
    #1;
    chk("cont_p4_ack", {15'd0, bus.cpu_ack}, 16'd0);

    // CPU write arriving at phase 1 (col 33): acked at phase 2
    while (bus.col != 10'd33) adv();
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 16'h5001;
    bus.cpu_wdata = 8'h77;
    #1;
    chk("wrc_p1_addr", bus.mem_addr, 16'h4415);
    chk("wrc_p1_ack", {15'd0, bus.cpu_ack}, 16'd0);
    adv();
    #1;
    chk("wrc_p2_ack", {15'd0, bus.cpu_ack}, 16'd1);
    chk("wrc_p2_we", {15'd0, bus.mem_we}, 16'd1);
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;

    // Line end: tile 15 has no successor, CPU owns phases 0/1
    while (bus.col != 10'd120) adv();
    #1;
    chk("end_tile15", {8'd0, bus.tile_ROM_addr}, 16'h009A);
    chk("end_pal15", {10'd0, bus.palette_ROM_addr}, 16'h0021);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 16'h5002;
    bus.cpu_wdata = 8'h55;
    #1;
    chk("end_p0_ack", {15'd0, bus.cpu_ack}, 16'd1);
    chk("end_p0_addr", bus.mem_addr, 16'h5002);
    adv();
    bus.cpu_we = 1'b0;
    #1;
    chk("end_p1_addr", bus.mem_addr, 16'h5002);
    chk("end_p1_ack", {15'd0, bus.cpu_ack}, 16'd0);
    adv();
    #1;
    chk("end_p2_ack", {15'd0, bus.cpu_ack}, 16'd1);
    chk("end_p2_rdata", {8'd0, bus.cpu_rdata}, 16'h0055);
    bus.cpu_req = 1'b0;
    adv();
    #1;
    chk("end_idle_addr", bus.mem_addr, 16'h0000);
    while (bus.col != 10'd128) adv();
    bus.de = 1'b0;
    #1;
    chk("end_tile0", {8'd0, bus.tile_ROM_addr}, 16'h0000);
    chk("end_pal0", {10'd0, bus.palette_ROM_addr}, 16'h0000);

    // Row 130: outside the window, line_start and de are ignored
    bus.row        = 9'd130;
    bus.col        = 10'd0;
    bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    #1;
    chk("r130_no_pre", bus.mem_addr, 16'h0000);
    tick();
    bus.de        = 1'b1;
    bus.col       = 10'd0;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 16'h5003;
    bus.cpu_wdata = 8'h66;
    #1;
    chk("r130_wr_ack", {15'd0, bus.cpu_ack}, 16'd1);
    chk("r130_wr_addr", bus.mem_addr, 16'h5003);
    adv();
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    #1;
    chk("r130_p1_addr", bus.mem_addr, 16'h0000);
    while (bus.col != 10'd8) adv();
    #1;
    chk("r130_tile", {8'd0, bus.tile_ROM_addr}, 16'h0000);
    chk("r130_pal", {10'd0, bus.palette_ROM_addr}, 16'h0000);
    bus.de = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tile_fetch_sched.md
# tile_fetch_sched

Fetch scheduler for the tilemap renderer. Each 8-pixel tile period it time-slices the single shared video RAM port between tile fetches and CPU accesses. Video fetches read the tile code and palette byte of the next tile. It double-buffers those bytes so the renderer sees stable `tile_ROM_addr` / `palette_ROM_addr` values for the whole tile. It sits between the raster timing generator, the CPU bus and video RAM, and feeds `tile_block`.

## Interface
Parameters:
- `TILE_BASE`, default 16'h4000: video RAM base of tile codes.
- `PAL_BASE`, default 16'h4400: video RAM base of palette bytes.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `row`  in  9  current raster line.
- `col`  in  10  current pixel column; advances by 1 every cycle while `de`=1.
- `de`  in  1  display enable (active pixel).
- `line_start`  in  1  one-cycle pulse during blanking, at least 3 cycles before `de` rises.
- `cpu_req`  in  1  CPU access request; held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  16  CPU address.
- `cpu_wdata`  in  8  CPU write data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  8  read data, valid while `cpu_ack`=1.
- `mem_addr`  out  16  video RAM address.
- `mem_we`  out  1  video RAM write strobe.
- `mem_wdata`  out  8  video RAM write data.
- `mem_rdata`  in  8  video RAM read data, valid the cycle after the address.
- `tile_ROM_addr`  out  8  tile code for the current tile.
- `palette_ROM_addr`  out  6  palette byte bits [5:0] for the current tile.

## Operation
- Display window: rows 0–127, cols 0–127, giving a 16×16 tile grid. Tile index t = `col[9:3]`; tile row r = `row[7:3]`.
- RAM offset for tile (r,t) = {r[3:0], t[3:0]}, zero-extended to 16 bits. Code address = `TILE_BASE`+offset; palette address = `PAL_BASE`+offset.
- Prefetch FSM, states IDLE, PRE_CODE, PRE_PAL, PRE_DONE:
  - IDLE → PRE_CODE on `line_start` with `row`<128. With `row`≥128, `line_start` is ignored.
  - PRE_CODE: issue code read for tile 0.
  - PRE_PAL: issue palette read; capture code into the next-buffer.
  - PRE_DONE: capture palette; load both output registers directly from the buffer/`mem_rdata`; → IDLE.
  - Each state lasts exactly one cycle.
- Active slots apply when `de`=1, FSM is IDLE and `row`<128, with phase = `col[2:0]`:
  - phase 0: issue code read for tile t+1.
  - phase 1: issue palette read for t+1; capture code.
  - phase 2: capture palette.
  - phase 7: transfer the next-buffer to `tile_ROM_addr` / `palette_ROM_addr`.
  - If t+1>15: no reads are issued, phases 0/1 are free for the CPU, and the phase-7 transfer loads 0 into both outputs.
- When `de` rises with the FSM not IDLE (spacing violated): the prefetch completes and active slots are suppressed until IDLE.
- CPU arbitration:
  - Video slots (PRE_CODE, PRE_PAL, active phases 0/1 with valid t+1) always win.
  - Every other cycle with `cpu_req`=1 and no CPU read outstanding is a CPU grant: `mem_addr`=`cpu_addr`, `mem_we`=`cpu_we`, `mem_wdata`=`cpu_wdata`.
  - Write grant: `cpu_ack` pulses in the grant cycle.
  - Read grant: `cpu_ack` pulses the next cycle, with `cpu_rdata`=`mem_rdata`.
  - The CPU must drop `cpu_req` or present a new request the cycle after `cpu_ack`.
- A CPU write to a tile already fetched does not change the buffered value; it takes effect on the next fetch.
- Idle memory port: `mem_addr`=0, `mem_we`=0.

## Timing
- Reset values: all outputs 0, FSM IDLE, buffers 0, no CPU read outstanding. Reset mid-access drops the access with no `cpu_ack`.
- Fetch to display: the tile t+1 code is read at phase 0 of tile t and appears on the outputs at the cycle after phase 7, i.e. when `col[2:0]`=0 of tile t+1. Outputs are constant for all 8 pixels of a tile.
- The `line_start` prefetch puts tile 0 on the outputs 3 cycles after the pulse.
- Worst-case CPU latency while `de`=1: 3 cycles (request arriving in phase 0). Outside active display: write 1 cycle, read 2 cycles.
- `mem_we` is only ever 1 during a CPU write grant.

## Test plan
- Reset: hold `rst` 2 cycles with `cpu_req`=1 → all outputs 0, no `cpu_ack`, `mem_we`=0.
- Prefetch: RAM[4000]=8'h12, RAM[4400]=8'h05; `line_start` with `row`=0 → 3 cycles later `tile_ROM_addr`=12, `palette_ROM_addr`=05.
- Active line `row`=8: RAM[4012]=AB, RAM[4412]=3F, scan `col` 8→23 → on `col`=16, outputs AB/3F. `mem_addr` is 4012 at `col`=8 and 4412 at `col`=9.
- CPU contention: `cpu_req` read of 0x5000 at phase 0 → granted at phase 2, `cpu_ack` at phase 3 with RAM data; CPU write at phase 1 → `cpu_ack` at phase 2.
- Line end: `col`=120–127 → no video reads at phases 0/1, CPU granted there, outputs 0 at `col`=128.
- `row`=130 with `line_start` and `de` → no video reads, outputs stay 0, CPU write acked in the grant cycle.
